// File: rtl/neuron_pkg.sv
// Shared types and helpers for the time-multiplexed fp32 neuron.
package neuron_pkg;

  localparam int unsigned FP_W = 32;
  localparam logic [FP_W-1:0] FP_ZERO = 32'h0;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_e;

  // Any value with the sign bit set (including -0.0 and negative NaN) maps to +0.0.
  function automatic logic [FP_W-1:0] fp_relu(input logic [FP_W-1:0] x);
    return x[FP_W-1] ? FP_ZERO : x;
  endfunction

endpackage

// File: rtl/float_adder.sv
// Combinational fp32 adder with guard/round/sticky alignment, round-to-nearest-even.
module float_adder (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o
);

  logic [31:0]        x, z;
  logic [7:0]         ex, ez, d;
  logic [26:0]        mx, mz, sh, n;
  logic [27:0]        s;
  logic [24:0]        r;
  logic [4:0]         lz;
  logic               sub, up;
  logic signed [9:0]  e;

  always_comb begin
    // x is the operand of larger magnitude, so it also supplies the result sign.
    if (a_i[30:0] >= b_i[30:0]) begin
      x = a_i;
      z = b_i;
    end else begin
      x = b_i;
      z = a_i;
    end
    ex = x[30:23];
    ez = z[30:23];
    mx = (ex == 8'd0) ? 27'd0 : {1'b1, x[22:0], 3'b0};
    mz = (ez == 8'd0) ? 27'd0 : {1'b1, z[22:0], 3'b0};
    d  = ex - ez;
    if (d >= 8'd27) begin
      sh = {26'b0, |mz};
    end else begin
      sh    = mz >> d;
      sh[0] = sh[0] | (|(mz & ~(27'h7FFFFFF << d)));
    end
    sub = x[31] ^ z[31];
    s   = sub ? ({1'b0, mx} - {1'b0, sh}) : ({1'b0, mx} + {1'b0, sh});
    e   = $signed({2'b0, ex});
    lz  = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (s[i]) lz = 5'(26 - i);
    end
    if (s[27]) begin
      n = {s[27:2], s[1] | s[0]};
      e = e + 10'sd1;
    end else begin
      n = s[26:0] << lz;
      e = e - $signed({5'b0, lz});
    end
    up = n[2] & (n[1] | n[0] | n[3]);
    r  = {1'b0, n[26:3]} + 25'(up);
    if (r[24]) e = e + 10'sd1;
    if (s == 28'd0) begin
      // Exact cancellation yields +0.0; only (-0)+(-0) keeps the sign.
      y_o = {~sub & x[31], 31'b0};
    end else if (e >= 10'sd255) begin
      y_o = {x[31], 8'hFF, 23'b0};
    end else if (e <= 10'sd0) begin
      y_o = {x[31], 31'b0};
    end else begin
      y_o = {x[31], e[7:0], r[24] ? r[23:1] : r[22:0]};
    end
  end

endmodule

// File: rtl/float_mult.sv
// Combinational fp32 multiplier, round-to-nearest-even; subnormals flush to signed zero.
module float_mult (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o
);

  logic [47:0]        p;
  logic [22:0]        m;
  logic [23:0]        r;
  logic               g, st, sgn;
  logic signed [9:0]  e;

  always_comb begin
    sgn = a_i[31] ^ b_i[31];
    p   = 48'({1'b1, a_i[22:0]}) * 48'({1'b1, b_i[22:0]});
    e   = $signed({2'b0, a_i[30:23]}) + $signed({2'b0, b_i[30:23]}) - 10'sd127;
    if (p[47]) begin
      m  = p[46:24];
      g  = p[23];
      st = |p[22:0];
      e  = e + 10'sd1;
    end else begin
      m  = p[45:23];
      g  = p[22];
      st = |p[21:0];
    end
    r = {1'b0, m} + 24'(g & (st | m[0]));
    // Carry out of rounding leaves the mantissa field all-zero.
    if (r[23]) e = e + 10'sd1;
    if (a_i[30:23] == 8'd0 || b_i[30:23] == 8'd0 || e <= 10'sd0) begin
      y_o = {sgn, 31'b0};
    end else if (e >= 10'sd255) begin
      y_o = {sgn, 8'hFF, 23'b0};
    end else begin
      y_o = {sgn, e[7:0], r[22:0]};
    end
  end

endmodule

// File: rtl/neuron_mac_dp.sv
// Datapath: captured input vector, operand mux by index, one multiplier, one adder, accumulator.
module neuron_mac_dp
  import neuron_pkg::*;
#(
  parameter int unsigned              N_IN   = 15,
  parameter logic [N_IN*FP_W-1:0]     W_FLAT = '0,
  parameter logic [FP_W-1:0]          BIAS   = FP_ZERO,
  localparam int unsigned             IdxW   = $clog2(N_IN)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   load_i,
  input  logic                   en_i,
  input  logic [N_IN*FP_W-1:0]   a_flat_i,
  input  logic [IdxW-1:0]        idx_i,
  output logic [FP_W-1:0]        sum_o
);

  logic [N_IN*FP_W-1:0] a_q, a_d;
  logic [FP_W-1:0]      acc_q, acc_d;
  logic [FP_W-1:0]      op_a, op_w, prod;

  assign op_a = a_q[idx_i*FP_W +: FP_W];
  assign op_w = W_FLAT[idx_i*FP_W +: FP_W];

  float_mult u_mult (
    .a_i (op_a),
    .b_i (op_w),
    .y_o (prod)
  );

  float_adder u_add (
    .a_i (acc_q),
    .b_i (prod),
    .y_o (sum_o)
  );

  always_comb begin
    a_d   = a_q;
    acc_d = acc_q;
    if (load_i) begin
      a_d   = a_flat_i;
      acc_d = BIAS;
    end else if (en_i) begin
      acc_d = sum_o;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q   <= '0;
      acc_q <= FP_ZERO;
    end else begin
      a_q   <= a_d;
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/neuron_mac_seq.sv
// Sequential fp32 neuron: y = act(BIAS + sum A[i]*W[i]) accumulated one term per cycle.
// Define NEURON_RELU_EN for a ReLU output; otherwise the output is linear.
module neuron_mac_seq
  import neuron_pkg::*;
#(
  parameter int unsigned          N_IN   = 15,
  parameter logic [N_IN*32-1:0]   W_FLAT = '0,
  parameter logic [31:0]          BIAS   = 32'h0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_IN*32-1:0]   a_flat,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          y
);

  localparam int unsigned IdxW = $clog2(N_IN);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(N_IN - 1);

  state_e          state_q;
  logic [IdxW-1:0] idx_q;
  logic [31:0]     y_q;
  logic            out_valid_q;
  logic [31:0]     sum;
  logic [31:0]     act_sum;
  logic            load, en;

  assign load = (state_q == IDLE) && in_valid;
  assign en   = (state_q == MAC);

  neuron_mac_dp #(
    .N_IN   (N_IN),
    .W_FLAT (W_FLAT),
    .BIAS   (BIAS)
  ) u_dp (
    .clk_i    (clk),
    .rst_i    (rst),
    .load_i   (load),
    .en_i     (en),
    .a_flat_i (a_flat),
    .idx_i    (idx_q),
    .sum_o    (sum)
  );

`ifdef NEURON_RELU_EN
  assign act_sum = fp_relu(sum);
`else
  assign act_sum = sum;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      y_q         <= FP_ZERO;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            idx_q   <= '0;
            state_q <= MAC;
          end
        end
        MAC: begin
          if (idx_q == IdxLast) begin
            y_q         <= act_sum;
            out_valid_q <= 1'b1;
            state_q     <= OUT;
          end else begin
            idx_q <= idx_q + IdxW'(1);
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign y         = y_q;

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Self-checking bench: four neuron instances against a real-arithmetic sequential golden model.
module tb_neuron_mac_seq;

  localparam logic [159:0] W5 = {32'hBDCCCCCD, 32'h41200000, 32'h3E4CCCCD,
                                 32'hC0490FDB, 32'h3F9D70A4};
  localparam logic [31:0]  B5 = 32'hBF2AAAAB;
  localparam logic [479:0] W15 = {15{32'h3F000000}};
  localparam logic [63:0]  W2 = {32'hBF800000, 32'h3FC00000};

  logic         clk = 1'b0;
  logic         rst;
  logic [479:0] af;
  logic         iv [4];
  logic         ordy [4];
  logic         ov [4];
  logic         ir [4];
  logic [31:0]  yv [4];
  int           errors = 0;
  int           checks = 0;

  always #5 clk = ~clk;

  neuron_mac_seq #(.N_IN(15), .W_FLAT(W15), .BIAS(32'h3E800000)) u15 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a_flat(af[479:0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .y(yv[0]));
  neuron_mac_seq #(.N_IN(4), .W_FLAT({4{32'hBF800000}}), .BIAS(32'h0)) u4 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a_flat(af[127:0]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .y(yv[1]));
  neuron_mac_seq #(.N_IN(2), .W_FLAT(W2), .BIAS(32'h0)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a_flat(af[63:0]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .y(yv[2]));
  neuron_mac_seq #(.N_IN(5), .W_FLAT(W5), .BIAS(B5)) u5 (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]), .a_flat(af[159:0]),
    .out_valid(ov[3]), .out_ready(ordy[3]), .y(yv[3]));

  function automatic real b2r(input logic [31:0] f);
    logic [10:0] de;
    de = {3'b0, f[30:23]} + 11'd896;
    if (f[30:23] == 8'd0) return $bitstoreal({f[31], 63'b0});
    return $bitstoreal({f[31], de, f[22:0], 29'b0});
  endfunction

  // Round a double to fp32 (nearest-even), flushing tiny values to signed zero.
  function automatic logic [31:0] r2b(input real r);
    logic [63:0] d;
    logic [24:0] m;
    int          e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'b0};
    e = int'(d[62:52]) - 896;
    m = {2'b01, d[51:29]} + 25'(d[28] & ((|d[27:0]) | d[29]));
    if (m[24]) begin
      e++;
      m = m >> 1;
    end
    if (e >= 255) return {d[63], 8'hFF, 23'b0};
    if (e <= 0) return {d[63], 31'b0};
    return {d[63], 8'(e), m[22:0]};
  endfunction

  function automatic logic [31:0] golden(input int n, input logic [479:0] a,
                                         input logic [479:0] w, input logic [31:0] bias);
    logic [31:0] acc, p;
    acc = bias;
    for (int i = 0; i < n; i++) begin
      p   = r2b(b2r(a[i*32 +: 32]) * b2r(w[i*32 +: 32]));
      acc = r2b(b2r(acc) + b2r(p));
    end
`ifdef NEURON_RELU_EN
    if (acc[31]) acc = 32'h0;
`endif
    return acc;
  endfunction

  function automatic logic [479:0] rand_vec();
    logic [479:0] v;
    for (int i = 0; i < 15; i++)
      v[i*32 +: 32] = {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 23'($urandom)};
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic transact(input int k, input int n, input logic [479:0] a,
                          input logic [31:0] exp_y, input string tag);
    int lat;
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(ir[k]), 32'd1);
    af    = a;
    iv[k] = 1'b1;
    @(posedge clk);
    #1;
    iv[k] = 1'b0;
    lat   = 0;
    while (!ov[k] && lat < n + 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(n));
    check({tag, "_y"}, yv[k], exp_y);
    check({tag, "_busy"}, 32'(ir[k]), 32'd0);
  endtask

  task automatic release_out(input int k, input string tag);
    @(negedge clk);
    ordy[k] = 1'b1;
    @(posedge clk);
    #1;
    ordy[k] = 1'b0;
    check({tag, "_ov_clr"}, 32'(ov[k]), 32'd0);
    check({tag, "_idle"}, 32'(ir[k]), 32'd1);
  endtask

  initial begin
    logic [479:0] v;
    logic [479:0] bv [3];
    logic [31:0]  e, be [3];
    int           acc_n, got, last_c;

    rst = 1'b1;
    af  = '0;
    for (int k = 0; k < 4; k++) begin
      iv[k]   = 1'b0;
      ordy[k] = 1'b0;
    end
    #2;
    for (int k = 0; k < 4; k++) begin
      check("rst_in_ready", 32'(ir[k]), 32'd1);
      check("rst_out_valid", 32'(ov[k]), 32'd0);
      check("rst_y", yv[k], 32'h0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;

    transact(0, 15, {15{32'h3F800000}}, 32'h40F80000, "ones15");
    release_out(0, "ones15");
`ifdef NEURON_RELU_EN
    transact(1, 4, {4{32'h3F800000}}, 32'h00000000, "neg4");
`else
    transact(1, 4, {4{32'h3F800000}}, 32'hC0800000, "neg4");
`endif
    release_out(1, "neg4");
    transact(2, 2, {32'h40400000, 32'h40000000}, 32'h00000000, "mix2");
    release_out(2, "mix2");

    for (int t = 0; t < 8; t++) begin
      v = rand_vec();
      transact(3, 5, v, golden(5, v, 480'(W5), B5), "rnd5");
      release_out(3, "rnd5");
    end
    for (int t = 0; t < 4; t++) begin
      v = rand_vec();
      transact(2, 2, v, golden(2, v, 480'(W2), 32'h0), "rnd2");
      release_out(2, "rnd2");
    end

    // Back-pressure: result must hold while new vectors are offered and refused.
    v = rand_vec();
    e = golden(15, v, W15, 32'h3E800000);
    transact(0, 15, v, e, "bp");
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      iv[0] = c[0];
      af    = rand_vec();
      @(posedge clk);
      #1;
      check("bp_ov_hold", 32'(ov[0]), 32'd1);
      check("bp_ir_low", 32'(ir[0]), 32'd0);
      check("bp_y_hold", yv[0], e);
    end
    @(negedge clk);
    iv[0] = 1'b0;
    release_out(0, "bp");
    repeat (3) @(posedge clk);
    #1;
    check("bp_not_taken", 32'(ir[0]), 32'd1);

    // Reset while idx==7 of a 15-input run.
    @(negedge clk);
    af    = rand_vec();
    iv[0] = 1'b1;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_ir", 32'(ir[0]), 32'd1);
    check("midrst_ov", 32'(ov[0]), 32'd0);
    check("midrst_y", yv[0], 32'h0);
    @(negedge clk);
    rst = 1'b0;
    v = rand_vec();
    transact(0, 15, v, golden(15, v, W15, 32'h3E800000), "postrst");
    release_out(0, "postrst");

    // Back-to-back with in_valid and out_ready held high.
    for (int i = 0; i < 3; i++) begin
      bv[i] = rand_vec();
      be[i] = golden(15, bv[i], W15, 32'h3E800000);
    end
    acc_n  = 0;
    got    = 0;
    last_c = 0;
    ordy[0] = 1'b1;
    for (int c = 0; c < 100 && got < 3; c++) begin
      @(negedge clk);
      if (ov[0]) begin
        check("b2b_y", yv[0], be[got]);
        if (got > 0) check("b2b_gap", 32'(c - last_c), 32'd17);
        last_c = c;
        got++;
      end
      if (ir[0]) begin
        if (acc_n < 3) begin
          af    = bv[acc_n];
          iv[0] = 1'b1;
          acc_n++;
        end else begin
          iv[0] = 1'b0;
        end
      end
    end
    check("b2b_count", 32'(got), 32'd3);
    iv[0]   = 1'b0;
    ordy[0] = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
